mc_control_fsm: RTL and testbench

Main control unit of the multicycle CPU. It is a Moore state machine that decodes the 6-bit opcode latched in the instruction register. It drives every datapath select and write-enable. Its ALUSrcA/ALUSrcB/PCSource/MemtoReg/RegDst/IorD outputs are the Sel inputs of the downstream twomux32 instances and the 4-way muxes.

---
 rtl/mc_pkg.sv | 79 +++++++
 rtl/mc_control_outdec.sv | 78 +++++++
 rtl/mc_control_fsm.sv | 84 ++++++++
 tb/tb_mc_control_fsm.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle CPU control path.
//   - opcode constants, FSM state encodings, ALU/mux select codes
//   - ctrl_t: control word produced by the state decoder
//   - decode_next(): DECODE-state dispatch on the opcode
// Optional feature macro: MC_CONTROL_ADDI_EN (adds the addi path).
package mc_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RTWB   = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

    // Successor of DECODE; S_FETCH means the opcode is not recognised.
    function automatic state_t decode_next(logic [OP_W-1:0] op);
        state_t nxt;
        nxt = S_FETCH;
        unique case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
            OP_J:         nxt = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
            OP_ADDI:      nxt = S_ADDIEX;
`endif
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_outdec.sv
// mc_control_outdec: combinational state -> control-word decoder.
//   state  in   current FSM state
//   ctrl   out  datapath selects and write enables for that state
// Optional feature macro: MC_CONTROL_ADDI_EN (decodes ADDIEX/ADDIWB).
module mc_control_outdec
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread  = 1'b1;
                ctrl.irwrite  = 1'b1;
                ctrl.alusrcb  = SRCB_FOUR;
                ctrl.aluop    = ALUOP_ADD;
                ctrl.pcsource = PCSRC_ALU;
                ctrl.pcwrite  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_B;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
`ifdef MC_CONTROL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore main control unit of the multicycle CPU.
//   Clk, Reset (async, active-high)  clock and reset
//   Op, Zero                         IR opcode and ALU zero flag
//   PCEn ... PCSource                datapath write enables and mux selects
//   IllegalOp                        pulse in DECODE on an unknown opcode
//   State                            current state (debug)
// Optional feature macro: MC_CONTROL_ADDI_EN (addi via ADDIEX/ADDIWB).
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int unsigned OPW = OP_W,
    parameter int unsigned SW_ = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [OPW-1:0] Op,
    input  logic           Zero,
    output logic           PCEn,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSource,
    output logic           IllegalOp,
    output logic [SW_-1:0] State
);

    state_t state_q;
    ctrl_t  ctrl;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
        end else begin
            case (state_q)
                S_INIT:   state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: state_q <= decode_next(Op);
                S_MEMADR: state_q <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_MEMWB:  state_q <= S_FETCH;
                S_MEMWR:  state_q <= S_FETCH;
                S_EXEC:   state_q <= S_RTWB;
                S_RTWB:   state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
`ifdef MC_CONTROL_ADDI_EN
                S_ADDIEX: state_q <= S_ADDIWB;
                S_ADDIWB: state_q <= S_FETCH;
`endif
                // Unused encodings recover through INIT.
                default:  state_q <= S_INIT;
            endcase
        end
    end

    mc_control_outdec u_outdec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Reset forces INIT asynchronously, so every strobe is already low during Reset.
    assign PCEn      = ctrl.pcwrite | (ctrl.pcwritecond & Zero);
    assign IorD      = ctrl.iord;
    assign MemRead   = ctrl.memread;
    assign MemWrite  = ctrl.memwrite;
    assign IRWrite   = ctrl.irwrite;
    assign MemtoReg  = ctrl.memtoreg;
    assign RegDst    = ctrl.regdst;
    assign RegWrite  = ctrl.regwrite;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ALUOp     = ctrl.aluop;
    assign PCSource  = ctrl.pcsource;
    assign IllegalOp = (state_q == S_DECODE) && (decode_next(Op) == S_FETCH);
    assign State     = SW_'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] Op = 6'b0;
    logic       Zero = 1'b0;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       IllegalOp;
    logic [3:0] State;

    mc_control_fsm dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Op        (Op),
        .Zero      (Zero),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .MemtoReg  (MemtoReg),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSource  (PCSource),
        .IllegalOp (IllegalOp),
        .State     (State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        out_t       o;
    } exp_t;

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic            zero;
        logic            ill;
        int              cpi;
        logic [4:0][3:0] seq;  // states after FETCH, seq[0] first
    } vec_t;

    out_t act;
    always_comb act = {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    exp_t sbq[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected control outputs for each state, straight from the state table.
    function automatic out_t exp_out(logic [3:0] st, logic z, logic ill);
        out_t o;
        o = '0;
        case (st)
            4'd1:  begin o.memread = 1; o.irwrite = 1; o.alusrcb = 2'b01; o.pcen = 1; end
            4'd2:  begin o.alusrcb = 2'b11; o.illegal = ill; end
            4'd3:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd4:  begin o.memread = 1; o.iord = 1; end
            4'd5:  begin o.regwrite = 1; o.memtoreg = 1; end
            4'd6:  begin o.memwrite = 1; o.iord = 1; end
            4'd7:  begin o.alusrca = 1; o.aluop = 2'b10; end
            4'd8:  begin o.regwrite = 1; o.regdst = 1; end
            4'd9:  begin o.alusrca = 1; o.aluop = 2'b01; o.pcsource = 2'b01; o.pcen = z; end
            4'd10: begin o.pcsource = 2'b10; o.pcen = 1; end
`ifdef MC_CONTROL_ADDI_EN
            4'd11: begin o.alusrca = 1; o.alusrcb = 2'b10; end
            4'd12: begin o.regwrite = 1; end
`endif
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push_exp(input logic [3:0] st, input out_t o);
        exp_t e;
        e.st = st;
        e.o  = o;
        sbq.push_back(e);
    endtask

    task automatic check_now(input string name);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, State=%0d", name, State);
            return;
        end
        e = sbq.pop_front();
        if (State !== e.st) begin
            n_bad++;
            $display("FAIL %s state: got %0d want %0d", name, State, e.st);
        end
        n_cmp++;
        if (act !== e.o) begin
            n_bad++;
            $display("FAIL %s outputs (state %0d): got %h want %h", name, e.st, act, e.o);
        end
    endtask

    // Entered with the DUT in FETCH; leaves it back in FETCH.
    task automatic run_vec(input vec_t v);
        @(negedge Clk);
        Op   = v.op;
        Zero = v.zero;
        for (int i = 0; i < v.cpi; i++)
            push_exp(v.seq[i], exp_out(v.seq[i], v.zero, v.ill && (v.seq[i] == 4'd2)));
        for (int i = 0; i < v.cpi; i++) begin
            @(posedge Clk);
            #1;
            check_now(v.name);
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{"lw",    6'b100011, 1'b0, 1'b0, 5, {4'd1, 4'd5, 4'd4, 4'd3, 4'd2}};
        vecs[1] = '{"sw",    6'b101011, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd3, 4'd2}};
        vecs[2] = '{"rtype", 6'b000000, 1'b1, 1'b0, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd2}};
        vecs[3] = '{"beq_z1", 6'b000100, 1'b1, 1'b0, 3, {4'd0, 4'd0, 4'd1, 4'd9, 4'd2}};
        vecs[4] = '{"beq_z0", 6'b000100, 1'b0, 1'b0, 3, {4'd0, 4'd0, 4'd1, 4'd9, 4'd2}};
        vecs[5] = '{"j",     6'b000010, 1'b0, 1'b0, 3, {4'd0, 4'd0, 4'd1, 4'd10, 4'd2}};
        vecs[6] = '{"ill",   6'b111111, 1'b1, 1'b1, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd2}};
`ifdef MC_CONTROL_ADDI_EN
        vecs[7] = '{"addi",  6'b001000, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd12, 4'd11, 4'd2}};
`else
        vecs[7] = '{"addi",  6'b001000, 1'b0, 1'b1, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd2}};
`endif

        // Reset held for 3 cycles, with Zero high to catch any PCEn leak.
        Reset = 1'b1;
        Zero  = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        push_exp(4'd0, '0);
        check_now("in_reset");
        @(negedge Clk);
        Reset = 1'b0;
        Zero  = 1'b0;
        #1;
        push_exp(4'd0, '0);
        check_now("init");
        @(posedge Clk);
        #1;
        push_exp(4'd1, exp_out(4'd1, 1'b0, 1'b0));
        check_now("first_fetch");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a store, while MemWrite is high.
        @(negedge Clk);
        Op    = 6'b101011;
        Zero  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge Clk);
            #1;
            if (State == 4'd6) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL reach_memwr: State=%0d want 6 within 8 cycles", State);
        end else begin
            push_exp(4'd6, exp_out(4'd6, 1'b1, 1'b0));
            check_now("memwr");
            #2;
            Reset = 1'b1;
            #1;
            push_exp(4'd0, '0);
            check_now("async_reset");
            @(posedge Clk);
            #1;
            push_exp(4'd0, '0);
            check_now("reset_hold");
            @(negedge Clk);
            Reset = 1'b0;
            Zero  = 1'b0;
            @(posedge Clk);
            #1;
            push_exp(4'd1, exp_out(4'd1, 1'b0, 1'b0));
            check_now("refetch");
            run_vec(vecs[0]);
        end

        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left want 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
